// File: rtl/btn_repeat_if.sv
// btn_repeat_if: bundle between the button command controller and the rest of
// the button lab.
//   up_lvl / dn_lvl : debounced button levels, synchronous to clk
//   clr             : synchronous clear of the counter
//   step_up/step_dn : one-cycle command pulses (registered)
//   count           : current counter value (registered)
//   locked          : high while both-button lockout is active (registered)
// The master modport is the side that supplies button levels; the slave
// modport is the controller itself.
interface btn_repeat_if #(
  parameter int WIDTH = 8
);
  logic             up_lvl;
  logic             dn_lvl;
  logic             clr;
  logic             step_up;
  logic             step_dn;
  logic [WIDTH-1:0] count;
  logic             locked;

  modport master (
    output up_lvl, dn_lvl, clr,
    input  step_up, step_dn, count, locked
  );

  modport slave (
    input  up_lvl, dn_lvl, clr,
    output step_up, step_dn, count, locked
  );
endinterface

// File: rtl/btn_repeat_ctrl.sv
// btn_repeat_ctrl: turns debounced up/down button levels into one-cycle step
// commands (immediate step on press, auto-repeat after a hold delay), locks
// out when both buttons are held, and owns the up/down counter register.
// Ports:
//   clk   : system clock, rising edge
//   rst_p : asynchronous reset, active-high
//   bus   : btn_repeat_if slave (up_lvl, dn_lvl, clr in; step_up, step_dn,
//           count, locked out). All outputs are registered.
// Parameters:
//   WIDTH      : counter width
//   HOLD_DLY   : cycles in HOLD before the first repeat step (>= 2)
//   REPEAT_PER : cycles between repeat steps (>= 1)
//   WRAP       : 1 = modulo wrap, 0 = saturate at 0 / 2^WIDTH-1
module btn_repeat_ctrl #(
  parameter int WIDTH      = 8,
  parameter int HOLD_DLY   = 4,
  parameter int REPEAT_PER = 2,
  parameter int WRAP       = 1
) (
  input  logic         clk,
  input  logic         rst_p,
  btn_repeat_if.slave  bus
);

  localparam int MAXD = (HOLD_DLY > REPEAT_PER) ? HOLD_DLY : REPEAT_PER;
  localparam int TW   = $clog2(MAXD);
  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_DLY - 1);
  localparam logic [TW-1:0] REP_END  = TW'(REPEAT_PER - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dir_q, dir_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             locked_q, locked_d;

  logic             latched_lvl;
  logic             opp_lvl;
  logic             step_due;

  // One counter step with wrap or clamp at the ends.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
    if (up) begin
      if (cur == CNT_MAX && WRAP == 0) return cur;
      return cur + WIDTH'(1);
    end
    if (cur == '0 && WRAP == 0) return cur;
    return cur - WIDTH'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dir_d       = dir_q;
    step_up_d   = 1'b0;
    step_dn_d   = 1'b0;
    latched_lvl = dir_q ? bus.up_lvl : bus.dn_lvl;
    opp_lvl     = dir_q ? bus.dn_lvl : bus.up_lvl;
    step_due    = (state_q == HOLD) ? (timer_q == HOLD_END) : (timer_q == REP_END);

    case (state_q)
      IDLE: begin
        if (bus.up_lvl && !bus.dn_lvl) begin
          step_up_d = 1'b1;
          dir_d     = 1'b1;
          timer_d   = '0;
          state_d   = HOLD;
        end else if (bus.dn_lvl && !bus.up_lvl) begin
          step_dn_d = 1'b1;
          dir_d     = 1'b0;
          timer_d   = '0;
          state_d   = HOLD;
        end else if (bus.up_lvl && bus.dn_lvl) begin
          state_d   = LOCK;
        end
      end
      HOLD, REPEAT: begin
        // Release is checked first so it wins over a step falling due.
        if (!latched_lvl) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (opp_lvl) begin
          state_d = LOCK;
          timer_d = '0;
        end else if (step_due) begin
          step_up_d = dir_q;
          step_dn_d = !dir_q;
          timer_d   = '0;
          state_d   = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      LOCK: begin
        // Only a full release leaves lockout; partial release never steps.
        if (!bus.up_lvl && !bus.dn_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a same-cycle step on the count only.
    if (bus.clr)        count_d = '0;
    else if (step_up_d) count_d = next_count(count_q, 1'b1);
    else if (step_dn_d) count_d = next_count(count_q, 1'b0);
    else                count_d = count_q;

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      dir_q     <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      count_q   <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      count_q   <= count_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.step_up = step_up_q;
  assign bus.step_dn = step_dn_q;
  assign bus.count   = count_q;
  assign bus.locked  = locked_q;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// tb_btn_repeat_ctrl: directed bench for btn_repeat_ctrl. Expected step
// commands are queued as stimulus is issued; a negedge monitor pops one entry
// per observed step pulse. A second, saturating instance covers WRAP=0.
module tb_btn_repeat_ctrl;

  logic clk;
  logic rst_p;

  btn_repeat_if #(.WIDTH(8)) m_if ();
  btn_repeat_if #(.WIDTH(8)) s_if ();

  btn_repeat_ctrl #(.WIDTH(8), .HOLD_DLY(4), .REPEAT_PER(2), .WRAP(1)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (m_if)
  );

  btn_repeat_ctrl #(.WIDTH(8), .HOLD_DLY(4), .REPEAT_PER(2), .WRAP(0)) dut_sat (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (s_if)
  );

  typedef struct {
    logic       up;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic up, input logic [7:0] cnt);
    exp_t x;
    x.up  = up;
    x.cnt = cnt;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every step pulse on the wrapping instance must match
  // the next queued expectation.
  always @(negedge clk) begin
    if (m_if.step_up || m_if.step_dn) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL step_unexpected: got up=%0b dn=%0b count=%0d, required no step",
                 m_if.step_up, m_if.step_dn, m_if.count);
      end else begin
        e = exp_q.pop_front();
        if (m_if.step_up !== e.up || m_if.step_dn !== !e.up || m_if.count !== e.cnt) begin
          n_bad++;
          $display("FAIL step_cmd: got up=%0b dn=%0b count=%0d, required up=%0b dn=%0b count=%0d",
                   m_if.step_up, m_if.step_dn, m_if.count, e.up, !e.up, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.up_lvl = 1'b0;
    m_if.dn_lvl = 1'b0;
    m_if.clr    = 1'b0;
    s_if.up_lvl = 1'b0;
    s_if.dn_lvl = 1'b0;
    s_if.clr    = 1'b0;
    rst_p       = 1'b0;

    // Reset values
    #2 rst_p = 1'b1;
    #1;
    check("rst_count",   m_if.count,   0);
    check("rst_locked",  m_if.locked,  0);
    check("rst_step_up", m_if.step_up, 0);
    check("rst_step_dn", m_if.step_dn, 0);
    cyc(2);
    rst_p = 1'b0;

    // Hold up E0..E9: steps at E0, E4, E6, E8
    m_if.up_lvl = 1'b1;
    push(1'b1, 8'd1); push(1'b1, 8'd2); push(1'b1, 8'd3); push(1'b1, 8'd4);
    cyc(10);
    m_if.up_lvl = 1'b0;
    cyc(1);
    check("hold_count",  m_if.count,  4);
    check("hold_locked", m_if.locked, 0);
    cyc(3);

    // Five single-cycle down presses: 4 -> 0 then wrap to 255
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 8'(3 - i));
      m_if.dn_lvl = 1'b1;
      cyc(1);
      m_if.dn_lvl = 1'b0;
      cyc(1);
    end
    check("wrap_down", m_if.count, 255);
    push(1'b1, 8'd0);
    m_if.up_lvl = 1'b1;
    cyc(1);
    m_if.up_lvl = 1'b0;
    cyc(1);
    check("wrap_up", m_if.count, 0);

    // Lockout: dn held, up joins at E2
    push(1'b0, 8'd255);
    m_if.dn_lvl = 1'b1;
    cyc(2);
    m_if.up_lvl = 1'b1;
    cyc(1);
    check("lock_enter", m_if.locked, 1);
    cyc(2);
    check("lock_stay", m_if.locked, 1);
    m_if.dn_lvl = 1'b0;
    cyc(2);
    check("lock_partial", m_if.locked, 1);
    check("lock_count",   m_if.count,  255);
    m_if.up_lvl = 1'b0;
    cyc(1);
    check("lock_exit",       m_if.locked, 0);
    check("lock_exit_count", m_if.count,  255);
    cyc(2);

    // Release on the edge the first repeat is due
    m_if.clr = 1'b1;
    cyc(1);
    m_if.clr = 1'b0;
    check("clr_idle", m_if.count, 0);
    push(1'b1, 8'd1);
    m_if.up_lvl = 1'b1;
    cyc(4);
    m_if.up_lvl = 1'b0;
    cyc(1);
    check("release_due_count", m_if.count, 1);
    cyc(2);
    push(1'b1, 8'd2);
    m_if.up_lvl = 1'b1;
    cyc(1);
    m_if.up_lvl = 1'b0;
    cyc(1);
    check("idle_after_release", m_if.count, 2);
    cyc(1);

    // clr on the same edge as a due repeat step (E8)
    m_if.clr = 1'b1;
    cyc(1);
    m_if.clr = 1'b0;
    check("clr_idle2", m_if.count, 0);
    m_if.up_lvl = 1'b1;
    push(1'b1, 8'd1); push(1'b1, 8'd2); push(1'b1, 8'd3); push(1'b1, 8'd0); push(1'b1, 8'd1);
    cyc(8);
    m_if.clr = 1'b1;
    cyc(1);
    m_if.clr = 1'b0;
    check("clr_step_pulse", m_if.step_up, 1);
    check("clr_step_count", m_if.count,   0);
    cyc(2);
    check("after_clr_repeat", m_if.count, 1);
    cyc(1);

    // Asynchronous reset mid-REPEAT with up still held
    #2 rst_p = 1'b1;
    #1;
    check("async_rst_count",  m_if.count,   0);
    check("async_rst_step",   m_if.step_up, 0);
    check("async_rst_locked", m_if.locked,  0);
    cyc(1);
    check("rst_held_count", m_if.count, 0);
    rst_p = 1'b0;
    push(1'b1, 8'd1);
    cyc(1);
    check("post_rst_step",  m_if.step_up, 1);
    check("post_rst_count", m_if.count,   1);
    m_if.up_lvl = 1'b0;
    cyc(3);

    // Saturating instance: climb to 255, then one more press
    s_if.up_lvl = 1'b1;
    for (int i = 0; i < 2000 && s_if.count != 8'hFF; i++) cyc(1);
    check("sat_reach_max", s_if.count, 255);
    s_if.up_lvl = 1'b0;
    cyc(2);
    s_if.up_lvl = 1'b1;
    cyc(1);
    check("sat_up_pulse", s_if.step_up, 1);
    check("sat_up_count", s_if.count,   255);
    s_if.up_lvl = 1'b0;
    cyc(1);
    check("sat_up_pulse_end", s_if.step_up, 0);
    cyc(1);
    s_if.clr = 1'b1;
    cyc(1);
    s_if.clr = 1'b0;
    cyc(1);
    check("sat_clr", s_if.count, 0);
    s_if.dn_lvl = 1'b1;
    cyc(1);
    check("sat_dn_pulse", s_if.step_dn, 1);
    check("sat_dn_count", s_if.count,   0);
    s_if.dn_lvl = 1'b0;
    cyc(3);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
